// File: rtl/hsv2rgb_if.sv
// Pixel-side bundle for the HSV -> RGB converter: clock enable, HSV pixel with
// video sync in, RGB pixel with delayed sync out.
interface hsv2rgb_if;
    logic       ce;
    logic       de_in;
    logic       hsync_in;
    logic       vsync_in;
    logic [7:0] H;
    logic [7:0] S;
    logic [7:0] V;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       de_out;
    logic       hsync_out;
    logic       vsync_out;

    modport master (
        output ce, de_in, hsync_in, vsync_in, H, S, V,
        input  red, green, blue, de_out, hsync_out, vsync_out
    );

    modport slave (
        input  ce, de_in, hsync_in, vsync_in, H, S, V,
        output red, green, blue, de_out, hsync_out, vsync_out
    );
endinterface

// File: rtl/hsv2rgb.sv
// Pipelined HSV -> RGB converter, latency 4 + OUT_REG ce-qualified cycles.
// Define HSV2RGB_BLANK_EN to force RGB to zero whenever the delayed de is low.
module hsv2rgb #(
    parameter int OUT_REG = 1
) (
    input  logic      clk,
    input  logic      rst,
    hsv2rgb_if.slave  bus
);

    // High byte of an unsigned 8x8 product; plain truncation, no rounding.
    function automatic logic [7:0] mul_hi(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] prod;
        prod = 16'(a) * 16'(b);
        return prod[15:8];
    endfunction

    logic [10:0] h6_p0;

    logic [2:0]  region_p1, region_p2, region_p3;
    logic [7:0]  rem_p1;
    logic [7:0]  s_p1, s_p2, s_p3;
    logic [7:0]  v_p1, v_p2, v_p3;
    logic [7:0]  sr_p2, snr_p2, ns_p2;
    logic [7:0]  p_p3, q_p3, t_p3;
    logic [7:0]  red_p4, green_p4, blue_p4;
    logic [7:0]  red_sel, green_sel, blue_sel;
    logic [2:0]  sync_p1, sync_p2, sync_p3, sync_p4;   // {de, hsync, vsync}

    logic [7:0]  red_q, green_q, blue_q;
    logic [2:0]  sync_q;

    assign h6_p0 = 11'(bus.H) * 11'd6;

    // Region codes 6 and 7 cannot occur, but fall back to grey like S == 0.
    always_comb begin
        red_sel   = v_p3;
        green_sel = v_p3;
        blue_sel  = v_p3;
        if (s_p3 != 8'd0) begin
            case (region_p3)
                3'd0: begin red_sel = v_p3; green_sel = t_p3; blue_sel = p_p3; end
                3'd1: begin red_sel = q_p3; green_sel = v_p3; blue_sel = p_p3; end
                3'd2: begin red_sel = p_p3; green_sel = v_p3; blue_sel = t_p3; end
                3'd3: begin red_sel = p_p3; green_sel = q_p3; blue_sel = v_p3; end
                3'd4: begin red_sel = t_p3; green_sel = p_p3; blue_sel = v_p3; end
                3'd5: begin red_sel = v_p3; green_sel = p_p3; blue_sel = q_p3; end
                default: begin red_sel = v_p3; green_sel = v_p3; blue_sel = v_p3; end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            region_p1 <= '0;
            rem_p1    <= '0;
            s_p1      <= '0;
            v_p1      <= '0;
            sync_p1   <= '0;
            region_p2 <= '0;
            s_p2      <= '0;
            v_p2      <= '0;
            sr_p2     <= '0;
            snr_p2    <= '0;
            ns_p2     <= '0;
            sync_p2   <= '0;
            region_p3 <= '0;
            s_p3      <= '0;
            v_p3      <= '0;
            p_p3      <= '0;
            q_p3      <= '0;
            t_p3      <= '0;
            sync_p3   <= '0;
            red_p4    <= '0;
            green_p4  <= '0;
            blue_p4   <= '0;
            sync_p4   <= '0;
        end else if (bus.ce) begin
            // Stage 1: hue sector and position within it
            region_p1 <= h6_p0[10:8];
            rem_p1    <= h6_p0[7:0];
            s_p1      <= bus.S;
            v_p1      <= bus.V;
            sync_p1   <= {bus.de_in, bus.hsync_in, bus.vsync_in};
            // Stage 2: saturation-scaled ramps
            region_p2 <= region_p1;
            s_p2      <= s_p1;
            v_p2      <= v_p1;
            sr_p2     <= mul_hi(s_p1, rem_p1);
            snr_p2    <= mul_hi(s_p1, 8'd255 - rem_p1);
            ns_p2     <= 8'd255 - s_p1;
            sync_p2   <= sync_p1;
            // Stage 3: value-scaled p/q/t
            region_p3 <= region_p2;
            s_p3      <= s_p2;
            v_p3      <= v_p2;
            p_p3      <= mul_hi(v_p2, ns_p2);
            q_p3      <= mul_hi(v_p2, 8'd255 - sr_p2);
            t_p3      <= mul_hi(v_p2, 8'd255 - snr_p2);
            sync_p3   <= sync_p2;
            // Stage 4: sector select
            red_p4    <= red_sel;
            green_p4  <= green_sel;
            blue_p4   <= blue_sel;
            sync_p4   <= sync_p3;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            // Stage 5: optional output register
            always_ff @(posedge clk) begin
                if (rst) begin
                    red_q   <= '0;
                    green_q <= '0;
                    blue_q  <= '0;
                    sync_q  <= '0;
                end else if (bus.ce) begin
                    red_q   <= red_p4;
                    green_q <= green_p4;
                    blue_q  <= blue_p4;
                    sync_q  <= sync_p4;
                end
            end
        end else begin : g_no_out_reg
            assign red_q   = red_p4;
            assign green_q = green_p4;
            assign blue_q  = blue_p4;
            assign sync_q  = sync_p4;
        end
    endgenerate

`ifdef HSV2RGB_BLANK_EN
    assign bus.red   = sync_q[2] ? red_q   : 8'd0;
    assign bus.green = sync_q[2] ? green_q : 8'd0;
    assign bus.blue  = sync_q[2] ? blue_q  : 8'd0;
`else
    assign bus.red   = red_q;
    assign bus.green = green_q;
    assign bus.blue  = blue_q;
`endif
    assign bus.de_out    = sync_q[2];
    assign bus.hsync_out = sync_q[1];
    assign bus.vsync_out = sync_q[0];

endmodule
